ixu_decode_stage: RTL and testbench

Registered, multi-lane IXU decode stage for the VLIW front end. Accepts an issue bundle of LANES 32-bit instructions per cycle over a valid/ready handshake and decodes each lane's RV32I integer ALU op (R-type 0110011, I-type 0010011, all-zero NOP). Outputs are registered: per-lane op, register indices, sign-extended immediate, and nop/illegal flags. Sits between the bundle fetch buffer and the IXU register-read stage, replacing the single-lane combinational decoder.

---
 rtl/ixu_decode_stage.sv | 166 ++++++++++++++++
 tb/tb_ixu_decode_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ixu_decode_stage.sv
// Registered multi-lane RV32I integer ALU decoder for the IXU issue path.
// Each lane decodes independently; illegal lanes are flagged, zeroed and counted.
module ixu_decode_stage #(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*32-1:0]   in_bundle,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*4-1:0]    out_op,
  output logic [LANES*5-1:0]    out_rs1,
  output logic [LANES*5-1:0]    out_rs2,
  output logic [LANES*5-1:0]    out_rd,
  output logic [LANES*XLEN-1:0] out_imm,
  output logic [LANES-1:0]      out_is_imm,
  output logic [LANES-1:0]      out_is_nop,
  output logic [LANES-1:0]      out_illegal,
  output logic [CNT_W-1:0]      illegal_cnt
);

  localparam int SUM_W = CNT_W + $clog2(LANES) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd2, OP_OR = 4'd3,
                         OP_AND = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_SLT = 4'd8, OP_SLTU = 4'd9;

  typedef struct packed {
    logic [3:0]      op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            is_imm;
    logic            is_nop;
    logic            illegal;
  } lane_t;

  function automatic lane_t decode_lane(input logic [31:0] inst);
    lane_t      r;
    logic       ok;
    logic       is_r;
    logic [3:0] op;
    logic [6:0] f7;
    r    = '0;
    ok   = 1'b0;
    op   = OP_ADD;
    f7   = inst[31:25];
    is_r = (inst[6:0] == OPC_R);
    if (inst == 32'd0) begin
      r.is_nop = 1'b1;
    end else begin
      if (is_r || inst[6:0] == OPC_I) begin
        // For I-type, only the shift forms constrain the upper immediate bits.
        case (inst[14:12])
          3'd0: begin
            ok = !is_r || f7 == 7'h00 || f7 == 7'h20;
            op = (is_r && f7[5]) ? OP_SUB : OP_ADD;
          end
          3'd1: begin ok = (f7 == 7'h00); op = OP_SLL; end
          3'd2: begin ok = !is_r || f7 == 7'h00; op = OP_SLT; end
          3'd3: begin ok = !is_r || f7 == 7'h00; op = OP_SLTU; end
          3'd4: begin ok = !is_r || f7 == 7'h00; op = OP_XOR; end
          3'd5: begin
            ok = (f7 == 7'h00) || (f7 == 7'h20);
            op = f7[5] ? OP_SRA : OP_SRL;
          end
          3'd6: begin ok = !is_r || f7 == 7'h00; op = OP_OR; end
          default: begin ok = !is_r || f7 == 7'h00; op = OP_AND; end
        endcase
      end
      if (ok) begin
        r.op  = op;
        r.rs1 = inst[19:15];
        r.rd  = inst[11:7];
        if (is_r) begin
          r.rs2 = inst[24:20];
        end else begin
          r.is_imm = 1'b1;
          r.imm    = XLEN'($signed(inst[31:20]));
        end
      end else begin
        r.illegal = 1'b1;
        r.is_nop  = 1'b1;
      end
    end
    return r;
  endfunction

  logic [LANES*4-1:0]    d_op;
  logic [LANES*5-1:0]    d_rs1, d_rs2, d_rd;
  logic [LANES*XLEN-1:0] d_imm;
  logic [LANES-1:0]      d_is_imm, d_is_nop, d_illegal;
  logic [SUM_W-1:0]      cnt_sum;
  logic                  accept;

  always_comb begin
    lane_t l;
    d_op      = '0;
    d_rs1     = '0;
    d_rs2     = '0;
    d_rd      = '0;
    d_imm     = '0;
    d_is_imm  = '0;
    d_is_nop  = '0;
    d_illegal = '0;
    cnt_sum   = SUM_W'(illegal_cnt);
    for (int k = 0; k < LANES; k++) begin
      l = decode_lane(in_bundle[32*k +: 32]);
      d_op[4*k +: 4]        = l.op;
      d_rs1[5*k +: 5]       = l.rs1;
      d_rs2[5*k +: 5]       = l.rs2;
      d_rd[5*k +: 5]        = l.rd;
      d_imm[XLEN*k +: XLEN] = l.imm;
      d_is_imm[k]           = l.is_imm;
      d_is_nop[k]           = l.is_nop;
      d_illegal[k]          = l.illegal;
      cnt_sum               = cnt_sum + SUM_W'(l.illegal);
    end
  end

  // Handshake: a bundle moves on a cycle where valid && ready are both high.
  // in_ready depends combinationally on out_ready and is held low during flush.
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_op      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_imm     <= '0;
      out_is_imm  <= '0;
      out_is_nop  <= '0;
      out_illegal <= '0;
      illegal_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_op      <= d_op;
      out_rs1     <= d_rs1;
      out_rs2     <= d_rs2;
      out_rd      <= d_rd;
      out_imm     <= d_imm;
      out_is_imm  <= d_is_imm;
      out_is_nop  <= d_is_nop;
      out_illegal <= d_illegal;
      illegal_cnt <= (cnt_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(cnt_sum);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ixu_decode_stage.sv
// Directed plus randomized bench for ixu_decode_stage (LANES=2, XLEN=32, CNT_W=4)
// against a table-driven reference decoder and an expected-bundle queue.
module tb_ixu_decode_stage;

  localparam int LANES = 2;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int W     = LANES * (4 + 5 + 5 + 5 + XLEN + 3);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // funct3 -> op when funct7 (or imm[11:5]) is zero
  localparam int base_op [8] = '{0, 5, 8, 9, 2, 6, 3, 4};

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*32-1:0]   in_bundle;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*4-1:0]    out_op;
  logic [LANES*5-1:0]    out_rs1, out_rs2, out_rd;
  logic [LANES*XLEN-1:0] out_imm;
  logic [LANES-1:0]      out_is_imm, out_is_nop, out_illegal;
  logic [CNT_W-1:0]      illegal_cnt;
  logic [W-1:0]          dut_flat;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic         m_valid;
  int           m_cnt;

  ixu_decode_stage #(.LANES(LANES), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_bundle(in_bundle),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_is_imm(out_is_imm), .out_is_nop(out_is_nop),
    .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  assign dut_flat = {out_op, out_rs1, out_rs2, out_rd, out_imm, out_is_imm, out_is_nop, out_illegal};

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decide the op code from the instruction fields, -1 if not legal.
  function automatic int ref_code(input logic [31:0] x);
    int f3 = int'(x[14:12]);
    int f7 = int'(x[31:25]);
    int code = -1;
    if (x[6:0] == 7'h33 || (x[6:0] == 7'h13 && (f3 == 1 || f3 == 5))) begin
      if (f7 == 0) code = base_op[f3];
      else if (f7 == 32 && f3 == 5) code = 7;
      else if (f7 == 32 && f3 == 0 && x[6:0] == 7'h33) code = 1;
    end else if (x[6:0] == 7'h13) begin
      code = base_op[f3];
    end
    return code;
  endfunction

  function automatic logic [W-1:0] ref_bundle(input logic [LANES*32-1:0] b, output int n_ill);
    logic [LANES*4-1:0]    op  = '0;
    logic [LANES*5-1:0]    rs1 = '0, rs2 = '0, rd = '0;
    logic [LANES*XLEN-1:0] imm = '0;
    logic [LANES-1:0]      ii = '0, nop = '0, ill = '0;
    logic [31:0]           x;
    int                    code;
    n_ill = 0;
    for (int k = 0; k < LANES; k++) begin
      x = b[32*k +: 32];
      code = ref_code(x);
      if (x == 32'd0) begin
        nop[k] = 1'b1;
      end else if (code < 0) begin
        ill[k] = 1'b1;
        nop[k] = 1'b1;
        n_ill++;
      end else begin
        op[4*k +: 4]  = 4'(code);
        rs1[5*k +: 5] = x[19:15];
        rd[5*k +: 5]  = x[11:7];
        if (x[6:0] == 7'h33) rs2[5*k +: 5] = x[24:20];
        else begin
          ii[k] = 1'b1;
          imm[XLEN*k +: XLEN] = {{(XLEN-12){x[31]}}, x[31:20]};
        end
      end
    end
    return {op, rs1, rs2, rd, imm, ii, nop, ill};
  endfunction

  // One clock: drive at posedge+1, check mid-cycle, advance the model, step.
  task automatic cycle(input logic v, input logic [LANES*32-1:0] b, input logic r, input logic f);
    logic exp_rdy;
    int   n_ill;
    logic [W-1:0] e;
    in_valid = v; in_bundle = b; out_ready = r; flush = f;
    #2;
    exp_rdy = !f && (!m_valid || r);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_valid);
    chk("illegal_cnt", illegal_cnt, m_cnt);
    if (m_valid) begin
      if (exp_q.size() == 0) chk("sb_empty", 1, 0);
      else chk("bundle", dut_flat, exp_q[0]);
    end
    if (m_valid && (r || f)) void'(exp_q.pop_front());
    if (v && exp_rdy) begin
      e = ref_bundle(b, n_ill);
      exp_q.push_back(e);
      m_cnt = (m_cnt + n_ill > CNT_MAX) ? CNT_MAX : m_cnt + n_ill;
      m_valid = 1'b1;
    end else if (f || r) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] x = $urandom;
    case ($urandom_range(0, 9))
      0: x = 32'd0;
      1, 2, 3: begin x[6:0] = 7'h33; x[31:25] = ($urandom_range(0, 3) == 0) ? 7'h20 :
                     ($urandom_range(0, 4) == 0) ? 7'($urandom) : 7'h00; end
      4, 5, 6: begin x[6:0] = 7'h13;
        if ($urandom_range(0, 1) == 1) x[31:25] = ($urandom_range(0, 2) == 0) ? 7'h20 :
                                                  ($urandom_range(0, 3) == 0) ? 7'h01 : 7'h00; end
      default: ;
    endcase
    return x;
  endfunction

  initial begin
    logic [LANES*32-1:0] b;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_bundle = '0;
    m_valid = 1'b0; m_cnt = 0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cnt", illegal_cnt, 0);
    chk("rst_data", dut_flat, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // sub x0,x1,x2 / addi x1,x0,-1
    cycle(1, {32'hFFF00093, 32'h40208033}, 1, 0);
    chk("sub_op", out_op[3:0], 4'd1);
    chk("sub_rs1", out_rs1[4:0], 5'd1);
    chk("sub_rs2", out_rs2[4:0], 5'd2);
    chk("sub_rd", out_rd[4:0], 5'd0);
    chk("sub_is_imm", out_is_imm[0], 1'b0);
    chk("addi_op", out_op[7:4], 4'd0);
    chk("addi_rd", out_rd[9:5], 5'd1);
    chk("addi_imm", out_imm[63:32], 32'hFFFFFFFF);
    chk("addi_is_imm", out_is_imm[1], 1'b1);

    // backpressure: held bundle, new one waits, then transfer+capture with no bubble
    for (int i = 0; i < 3; i++) cycle(1, {32'h00a50513, 32'h00c5f6b3}, 0, 0);
    cycle(1, {32'h00a50513, 32'h00c5f6b3}, 1, 0);

    // illegal pair: add with funct7=01, jal
    cycle(1, {32'h0000006F, 32'h02000033}, 1, 0);
    chk("ill_flags", out_illegal, 2'b11);
    chk("ill_nop", out_is_nop, 2'b11);
    chk("ill_cnt", illegal_cnt, 2);

    // shift-imm: srai legal, slli with imm[11:5]=01 illegal
    cycle(1, {32'h02011093, 32'h40515093}, 1, 0);
    chk("srai_op", out_op[3:0], 4'd7);
    chk("shift_ill", out_illegal, 2'b10);

    for (int i = 0; i < 400; i++) begin
      b = {rand_inst(), rand_inst()};
      cycle(1'($urandom_range(0, 3) != 0), b, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 19) == 0));
    end

    // saturation, then flush with a bundle presented
    for (int i = 0; i < 10; i++) cycle(1, {32'h0000006F, 32'h02000033}, 1, 0);
    cycle(0, '0, 0, 0);
    chk("sat_cnt", illegal_cnt, CNT_MAX);
    cycle(1, {32'h0000006F, 32'h00000000}, 0, 1);
    cycle(0, '0, 0, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_cnt", illegal_cnt, CNT_MAX);

    // asynchronous reset while holding a bundle
    cycle(1, {32'h00000000, 32'h0000006F}, 0, 0);
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_cnt", illegal_cnt, 0);
    m_valid = 1'b0; m_cnt = 0; exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) cycle(1, {rand_inst(), rand_inst()}, 1'($urandom_range(0, 1)), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
